// File: rtl/receive_if.sv
// -----------------------------------------------------------------------------
// receive_if : serial-in / byte-out bundle for the UART receiver.
//
//   in     serial line, idles high (driven by the line source)
//   sgn    one-cycle strobe, data holds a newly received byte
//   error  one-cycle strobe, framing error (stop bit sampled low)
//   data   last correctly received byte
//
// master : the line source / byte consumer side
// slave  : the receiver
// -----------------------------------------------------------------------------
interface receive_if;
    logic       in;
    logic       sgn;
    logic       error;
    logic [7:0] data;

    modport master (output in, input sgn, input error, input data);
    modport slave  (input in, output sgn, output error, output data);
endinterface

// File: rtl/receive.sv
// -----------------------------------------------------------------------------
// receive : UART 8N1 receiver, mid-bit sampling from a clk-oversampled line.
//
// Parameters
//   CLKS_PER_BIT  clock cycles per bit period (even, 4..65534), default 16
//
// Ports
//   clk   system clock, rising edge
//   rst   synchronous active-low reset
//   bus   receive_if.slave : in (serial line), sgn / error strobes, data byte
//
// Build option
//   RECEIVE_SYNC_EN  when defined, in passes through a two-flop synchronizer
//                    (reset to idle-high) before use; all timing moves by +2
//                    cycles relative to in. When undefined, in must already be
//                    synchronous to clk.
// -----------------------------------------------------------------------------
module receive #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    receive_if.slave   bus
);

    // The counter only ever reaches CLKS_PER_BIT-1 before being cleared.
    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } state_t;

    state_t          state_r, state_s;
    logic [CW-1:0]   cnt_r,   cnt_s;
    logic [2:0]      bit_r,   bit_s;
    logic [7:0]      shift_r, shift_s;
    logic [7:0]      data_r,  data_s;
    logic            sgn_r,   sgn_s;
    logic            error_r, error_s;
    logic            rx_s;

`ifdef RECEIVE_SYNC_EN
    logic [1:0] sync_r;

    // Two-flop synchronizer; resets to the idle (high) line level.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_r <= 2'b11;
        end else begin
            sync_r <= {sync_r[0], bus.in};
        end
    end

    assign rx_s = sync_r[1];
`else
    assign rx_s = bus.in;
`endif

    // Next-state, sampling and strobe logic.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r + CNT_ONE;
        bit_s   = bit_r;
        shift_s = shift_r;
        data_s  = data_r;
        sgn_s   = 1'b0;
        error_s = 1'b0;

        case (state_r)
            IDLE: begin
                cnt_s = CNT_ZERO;
                if (!rx_s) begin
                    state_s = START;
                end else begin
                    state_s = IDLE;
                end
            end

            START: begin
                // Re-check the line at the middle of the start bit to reject glitches.
                if (cnt_r == HALF_M1) begin
                    cnt_s = CNT_ZERO;
                    bit_s = 3'd0;
                    if (rx_s) begin
                        state_s = IDLE;
                    end else begin
                        state_s = DATA;
                    end
                end else begin
                    state_s = START;
                end
            end

            DATA: begin
                if (cnt_r == FULL_M1) begin
                    cnt_s = CNT_ZERO;
                    // Shift right so the first (LSB) bit ends up in bit 0.
                    shift_s = {rx_s, shift_r[7:1]};
                    if (bit_r == 3'd7) begin
                        state_s = STOP;
                        bit_s   = 3'd0;
                    end else begin
                        state_s = DATA;
                        bit_s   = bit_r + 3'd1;
                    end
                end else begin
                    state_s = DATA;
                end
            end

            STOP: begin
                if (cnt_r == FULL_M1) begin
                    cnt_s = CNT_ZERO;
                    if (rx_s) begin
                        data_s  = shift_r;
                        sgn_s   = 1'b1;
                        state_s = IDLE;
                    end else begin
                        error_s = 1'b1;
                        state_s = BREAK;
                    end
                end else begin
                    state_s = STOP;
                end
            end

            BREAK: begin
                // A held-low line reports one error only; wait for it to return high.
                cnt_s = CNT_ZERO;
                if (rx_s) begin
                    state_s = IDLE;
                end else begin
                    state_s = BREAK;
                end
            end

            default: begin
                cnt_s   = CNT_ZERO;
                state_s = IDLE;
            end
        endcase
    end

    // State, counters, shift register and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= IDLE;
            cnt_r   <= CNT_ZERO;
            bit_r   <= 3'd0;
            shift_r <= 8'h00;
            data_r  <= 8'h00;
            sgn_r   <= 1'b0;
            error_r <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            bit_r   <= bit_s;
            shift_r <= shift_s;
            data_r  <= data_s;
            sgn_r   <= sgn_s;
            error_r <= error_s;
        end
    end

    assign bus.sgn   = sgn_r;
    assign bus.error = error_r;
    assign bus.data  = data_r;

endmodule

// File: tb/tb_receive.sv
module tb_receive;

    localparam int N = 16;
`ifdef RECEIVE_SYNC_EN
    localparam int LAT = 155;
`else
    localparam int LAT = 153;
`endif

    logic clk;
    logic rst;
    int   cyc;
    int   checks;
    int   failures;

    receive_if bus ();

    receive #(.CLKS_PER_BIT(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic       is_err;
        logic [7:0] data;
        int         cyc;
    } exp_t;

    exp_t q[$];
    exp_t e;

    // Monitor: every strobe must match the head of the expectation queue.
    always @(negedge clk) begin
        if (bus.sgn || bus.error) begin
            checks++;
            if (bus.sgn && bus.error) begin
                failures++;
                $display("FAIL both_strobes cyc=%0d sgn=%b error=%b required one only", cyc, bus.sgn, bus.error);
            end
            if (q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_strobe cyc=%0d sgn=%b error=%b data=%h required none", cyc, bus.sgn, bus.error, bus.data);
            end else begin
                e = q.pop_front();
                checks += 3;
                if (bus.error !== e.is_err || bus.sgn !== !e.is_err) begin
                    failures++;
                    $display("FAIL strobe_kind cyc=%0d sgn=%b error=%b required error=%b", cyc, bus.sgn, bus.error, e.is_err);
                end
                if (bus.data !== e.data) begin
                    failures++;
                    $display("FAIL data cyc=%0d got=%h required=%h", cyc, bus.data, e.data);
                end
                if (cyc != e.cyc) begin
                    failures++;
                    $display("FAIL strobe_time got_cyc=%0d required_cyc=%0d", cyc, e.cyc);
                end
            end
        end
    end

    task automatic drive(input logic v, input int n);
        bus.in = v;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Send one frame; if push, the expected strobe is queued first.
    task automatic send(input logic [7:0] b, input logic stop_v, input logic push,
                        input logic is_err, input logic [7:0] exp_data);
        exp_t x;
        if (push) begin
            x.is_err = is_err;
            x.data   = exp_data;
            x.cyc    = cyc + LAT;
            q.push_back(x);
        end
        drive(1'b0, N);
        for (int i = 0; i < 8; i++) drive(b[i], N);
        drive(stop_v, N);
    endtask

    task automatic check_val(input string name, input logic [7:0] got, input logic [7:0] req);
        checks++;
        if (got !== req) begin
            failures++;
            $display("FAIL %s got=%h required=%h", name, got, req);
        end
    endtask

    logic [7:0] partial;

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b0;
        bus.in   = 1'b1;

        // Reset with the line toggling.
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            bus.in = ~bus.in;
        end
        @(negedge clk);
        check_val("reset_data", bus.data, 8'h00);
        check_val("reset_sgn", {7'd0, bus.sgn}, 8'h00);
        check_val("reset_error", {7'd0, bus.error}, 8'h00);
        @(posedge clk);
        #1;
        bus.in = 1'b1;
        rst    = 1'b1;
        drive(1'b1, 20);

        // Valid frame A5.
        send(8'hA5, 1'b1, 1'b1, 1'b0, 8'hA5);
        drive(1'b1, 20);

        // Framing error on 3C, then a good 81.
        send(8'h3C, 1'b0, 1'b1, 1'b1, 8'hA5);
        drive(1'b1, 20);
        check_val("data_after_error", bus.data, 8'hA5);
        send(8'h81, 1'b1, 1'b1, 1'b0, 8'h81);
        drive(1'b1, 20);

        // Short glitch, then 5A.
        drive(1'b0, 4);
        drive(1'b1, 20);
        send(8'h5A, 1'b1, 1'b1, 1'b0, 8'h5A);
        drive(1'b1, 20);

        // Back-to-back 00 and FF; queued times are 160 cycles apart.
        send(8'h00, 1'b1, 1'b1, 1'b0, 8'h00);
        send(8'hFF, 1'b1, 1'b1, 1'b0, 8'hFF);
        drive(1'b1, 20);

        // Reset during data bit 4, then 12.
        partial = 8'h77;
        drive(1'b0, N);
        for (int i = 0; i < 4; i++) drive(partial[i], N);
        drive(partial[4], N / 2);
        rst = 1'b0;
        drive(1'b1, 3);
        rst = 1'b1;
        @(negedge clk);
        check_val("data_after_midframe_reset", bus.data, 8'h00);
        @(posedge clk);
        #1;
        drive(1'b1, 20);
        send(8'h12, 1'b1, 1'b1, 1'b0, 8'h12);

        // Bounded drain of outstanding expectations.
        for (int i = 0; i < 400 && q.size() != 0; i++) @(posedge clk);
        drive(1'b1, 10);
        while (q.size() != 0) begin
            e = q.pop_front();
            checks++;
            failures++;
            $display("FAIL missing_strobe required_cyc=%0d error=%b data=%h got none", e.cyc, e.is_err, e.data);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/receive.md
# receive

UART serial receiver: recovers 8N1 frames (1 start, 8 data bits LSB first, 1 stop) from a single-bit line oversampled by the system clock. It samples at mid-bit, presents the received byte on a parallel bus with a one-cycle strobe, and flags framing errors. It sits between the external RX pin and the byte-consuming logic.

## Interface
- CLKS_PER_BIT, default 16: clock cycles per bit period; even, 4..65534.
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  synchronous, active-low reset.
- in  input  1  serial line; idles high.
- sgn  output  1  one-cycle strobe; data holds a new valid byte.
- error  output  1  one-cycle strobe; framing error (stop bit sampled low).
- data  output  8  last correctly received byte; held until the next valid frame.

## Operation
- States: IDLE, START, DATA, STOP, BREAK.
- IDLE: wait for rx=0, where rx is the sampled line. Enter START and clear the counter.
- START: at half bit (CLKS_PER_BIT/2 cycles after detection), re-sample rx.
  - rx=1: false start. Return to IDLE with no strobes.
  - rx=0: enter DATA.
- DATA: sample every CLKS_PER_BIT cycles. Shift samples into a register LSB first (bit0 first). After 8 samples, enter STOP.
- STOP: sample once, CLKS_PER_BIT cycles after bit7.
  - rx=1: load data with the shift register, pulse sgn, go to IDLE.
  - rx=0: pulse error, leave data unchanged, go to BREAK.
- BREAK: wait until rx=1, then go to IDLE. A held-low line produces one error only.
- sgn and error are never high in the same cycle.
- rst=0 at a clock edge:
  - state goes to IDLE, all counters clear, the shift register clears.
  - data=8'h00, sgn=0, error=0.
  - Reset mid-frame aborts the frame with no strobe.

## Timing
- Cycle 0 is the clock edge at which IDLE first sees rx=0. Let H = CLKS_PER_BIT/2 and N = CLKS_PER_BIT.
- Start-bit check: edge H.
- Data bit k (k=0..7): sampled at edge H + N·(k+1).
- Stop bit: sampled at edge H + 9N. With the default N=16 this is edge 152.
- sgn/error: registered. High for exactly the cycle after the stop-sample edge. data updates on that same edge.
- The receiver is back in IDLE after the stop sample, at mid-stop. A new start edge is accepted from then on, giving ±N/2 tolerance for back-to-back frames.
- The counter is wide enough for CLKS_PER_BIT and does not wrap within a bit period.

## Configuration
- RECEIVE_SYNC_EN defined:
  - in passes through a two-flop synchronizer (both flops reset to 1) before use as rx.
  - Every timing figure above is shifted by +2 cycles relative to in.
- RECEIVE_SYNC_EN undefined:
  - rx = in directly.
  - The source must be synchronous to clk.

## Test plan
- Reset: hold rst=0 for 5 cycles with in toggling. Required: data=8'h00, sgn=0, error=0, no strobe after release while in=1.
- Valid frame, N=16: line 0, then bits 1,0,1,0,0,1,0,1, then 1, each 16 cycles. Required: data=8'hA5; sgn high for exactly one cycle, at cycle 153 after the falling edge (155 with RECEIVE_SYNC_EN); error stays 0.
- Framing error: send 8'h3C with the stop bit low, then line high. Required: error pulses once; sgn=0; data keeps the previous 8'hA5; the next valid frame 8'h81 yields sgn and data=8'h81.
- Glitch: in low for 4 cycles, then high. Required: no sgn, no error; the receiver accepts a following 8'h5A frame correctly.
- Back-to-back: frames 8'h00 and 8'hFF with no idle gap. Required: two sgn pulses 160 cycles apart, data=8'h00 then 8'hFF.
- Reset mid-frame: assert rst=0 at data bit 4 of a frame, release, then send 8'h12. Required: no strobe for the aborted frame; data=8'h12 with one sgn.
